// File: rtl/long_divider_pkg.sv
// Shared definitions for the long divider: controller state encoding and counter sizing.
package long_divider_pkg;

  localparam int SWIDTH = 3;

  typedef enum logic [SWIDTH-1:0] {
    WAIT_FOR_START       = 3'd0,
    CHECK_DIVIDE_BY_ZERO = 3'd1,
    ERROR                = 3'd2,
    SHIFT_SUBTRACT       = 3'd3,
    FIX_SIGN             = 3'd4,
    DONE                 = 3'd5
  } state_e;

  // Iteration counter width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/long_divider_ctrl.sv
// Long divider controller: sequencing FSM plus the per-bit iteration counter.
module long_divider_ctrl
  import long_divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic divisor_zero,
  output logic load,
  output logic iterate,
  output logic fix_sign,
  output logic write_err,
  output logic busy,
  output logic done,
  output logic error_set
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             count_zero;

  assign count_zero = (count_q == '0);

  // NOTE: every output and next-state value gets a default before the case,
  // so no path through the block can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    load      = 1'b0;
    iterate   = 1'b0;
    fix_sign  = 1'b0;
    write_err = 1'b0;
    error_set = 1'b0;
    done      = 1'b0;

    case (state_q)
      WAIT_FOR_START: begin
        if (start) begin
          load    = 1'b1;
          state_d = CHECK_DIVIDE_BY_ZERO;
        end
      end
      CHECK_DIVIDE_BY_ZERO: begin
        if (divisor_zero) begin
          write_err = 1'b1;
          error_set = 1'b1;
          state_d   = ERROR;
        end else begin
          count_d = CNT_LAST;
          state_d = SHIFT_SUBTRACT;
        end
      end
      SHIFT_SUBTRACT: begin
        iterate = 1'b1;
        if (count_zero) state_d = FIX_SIGN;
        else            count_d = count_q - 1'b1;
      end
      FIX_SIGN: begin
        fix_sign = 1'b1;
        state_d  = DONE;
      end
      ERROR: begin
        done    = 1'b1;
        state_d = WAIT_FOR_START;
      end
      DONE: begin
        done    = 1'b1;
        state_d = WAIT_FOR_START;
      end
      default: state_d = WAIT_FOR_START;
    endcase
  end

  assign busy = (state_q != WAIT_FOR_START);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_FOR_START;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/long_divider.sv
// Iterative restoring long divider: one quotient bit per clock, optional signed mode,
// divide-by-zero reporting and a start/busy/done handshake.
module long_divider
  import long_divider_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int MW = WIDTH + 1;

  logic load, iterate, fix_sign, write_err, error_set, divisor_zero;

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [MW-1:0]    rem_q, rem_d;
  logic [MW-1:0]    dvs_mag_q, dvs_mag_d;
  logic [WIDTH-1:0] dvd_raw_q, dvd_raw_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             error_q, error_d;

  logic             mode, dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [MW-1:0]    dvs_mag_w;
  logic [MW:0]      shifted, diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_low, q_fix, r_fix;

  long_divider_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .divisor_zero(divisor_zero),
    .load        (load),
    .iterate     (iterate),
    .fix_sign    (fix_sign),
    .write_err   (write_err),
    .busy        (busy),
    .done        (done),
    .error_set   (error_set)
  );

  // Operand conditioning: magnitudes are WIDTH+1 wide so |most-negative| fits.
  assign mode      = SIGNED_EN ? signed_mode : 1'b0;
  assign dvd_neg   = mode & dividend[WIDTH-1];
  assign dvs_neg   = mode & divisor[WIDTH-1];
  assign dvd_mag   = dvd_neg ? -dividend : dividend;
  assign dvs_mag_w = {1'b0, (dvs_neg ? -divisor : divisor)};

  assign divisor_zero = (dvs_mag_q == '0);

  // One restoring step: shift {rem, quo} left, then trial-subtract the divisor.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_mag_q};
  assign borrow  = diff[MW];

  assign rem_low = WIDTH'(rem_q);
  assign q_fix   = q_neg_q ? -quo_q : quo_q;
  assign r_fix   = r_neg_q ? -rem_low : rem_low;

  always_comb begin
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_mag_d   = dvs_mag_q;
    dvd_raw_d   = dvd_raw_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    error_d     = error_q;

    if (load) begin
      quo_d     = dvd_mag;
      rem_d     = '0;
      dvs_mag_d = dvs_mag_w;
      dvd_raw_d = dividend;
      q_neg_d   = dvd_neg ^ dvs_neg;
      r_neg_d   = dvd_neg;
      error_d   = 1'b0;
    end

    if (iterate) begin
      quo_d = {quo_q[WIDTH-2:0], ~borrow};
      rem_d = borrow ? MW'(shifted) : MW'(diff);
    end

    if (write_err) begin
      quotient_d  = '1;
      remainder_d = dvd_raw_q;
    end
    if (error_set) error_d = 1'b1;

    if (fix_sign) begin
      quotient_d  = q_fix;
      remainder_d = r_fix;
    end
  end

  // NOTE: the working registers are reset along with the outputs, so an
  // aborted operation leaves nothing stale behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_mag_q   <= '0;
      dvd_raw_q   <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      error_q     <= 1'b0;
    end else begin
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_mag_q   <= dvs_mag_d;
      dvd_raw_q   <= dvd_raw_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      error_q     <= error_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign error     = error_q;

endmodule

// File: tb/tb_long_divider.sv
// Scoreboard bench for long_divider (WIDTH=8): stimulus pushes expected results,
// a negedge monitor pops and compares them whenever done is seen.
module tb_long_divider;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       signed_mode;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       error;

  long_divider #(.WIDTH(8), .SIGNED_EN(1'b1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .signed_mode(signed_mode),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       e;
    int         at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Called on a negedge: cycle 0 is the one ending in the start-sampling edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic sm,
                          input logic [7:0] eq, input logic [7:0] er, input logic ee,
                          input bit push);
    dividend    = a;
    divisor     = b;
    signed_mode = sm;
    start       = 1'b1;
    if (push) sb.push_back('{q: eq, r: er, e: ee, at: cyc + (ee ? 2 : 11)});
    @(negedge clk);
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        mon_e = sb.pop_front();
        check("quotient",   quotient, mon_e.q);
        check("remainder",  remainder, mon_e.r);
        check("error",      error, mon_e.e);
        check("done_cycle", cyc, mon_e.at);
      end
    end
  end

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    dividend    = '0;
    divisor     = '0;
    repeat (3) @(negedge clk);
    check("rst_quotient",  quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_error",     error, 0);
    check("rst_busy",      busy, 0);
    check("rst_done",      done, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Unsigned 100/7, busy through cycles 1..10
    check("busy_idle", busy, 0);
    start_op(8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      check("busy_run", busy, 1);
      @(negedge clk);
    end
    @(negedge clk);
    check("busy_after", busy, 0);

    // Divide by zero; error held until the next accepted start
    start_op(8'd55, 8'd0, 1'b0, 8'hFF, 8'd55, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("error_hold",    error, 1);
    check("quotient_hold", quotient, 8'hFF);

    // Signed cases
    start_op(8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 1'b1);
    check("error_cleared", error, 0);
    repeat (11) @(negedge clk);
    start_op(8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0, 1'b1);
    repeat (11) @(negedge clk);
    start_op(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 1'b1);
    repeat (11) @(negedge clk);
    start_op(8'h80, 8'hFF, 1'b0, 8'h00, 8'h80, 1'b0, 1'b1);
    repeat (11) @(negedge clk);

    // 200/3 with a stray start in cycle 5, then a new start in cycle 12
    start_op(8'd200, 8'd3, 1'b0, 8'd66, 8'd2, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    dividend = 8'd10;
    divisor  = 8'd0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    start_op(8'd9, 8'd4, 1'b0, 8'd2, 8'd1, 1'b0, 1'b1);
    repeat (11) @(negedge clk);

    // start held high: back-to-back operations, next accepted the cycle after done
    dividend    = 8'd20;
    divisor     = 8'd6;
    signed_mode = 1'b0;
    start       = 1'b1;
    sb.push_back('{q: 8'd3, r: 8'd2, e: 1'b0, at: cyc + 11});
    sb.push_back('{q: 8'd3, r: 8'd2, e: 1'b0, at: cyc + 23});
    repeat (13) @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);

    // Reset in cycle 6 of an operation aborts it with no done
    start_op(8'd100, 8'd7, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_quotient",  quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_error",     error, 0);
    check("abort_busy",      busy, 0);
    check("abort_done",      done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    start_op(8'd255, 8'd1, 1'b0, 8'd255, 8'd0, 1'b0, 1'b1);
    repeat (11) @(negedge clk);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
